// File: rtl/exception_ctrl_pkg.sv
// Shared constants for the MEM-stage exception controller: ExcCodes, CP0 register
// addresses, request-flag bit positions and FSM state encoding.
package exception_ctrl_pkg;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;
   localparam logic [4:0] EXC_TRAP = 5'h0d;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   localparam int EXC_BIT_SYSCALL = 0;
   localparam int EXC_BIT_RI      = 1;
   localparam int EXC_BIT_OV      = 2;
   localparam int EXC_BIT_TRAP    = 3;
   localparam int EXC_BIT_ERET    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // A delay-slot instruction restarts at its branch, one word earlier.
   function automatic logic [31:0] fault_epc(input logic [31:0] pc, input logic bd);
      return bd ? (pc - 32'd4) : pc;
   endfunction

endpackage

// File: rtl/exception_ctrl_int_sync.sv
// Single-bit multi-flop synchroniser for one asynchronous interrupt line.
module exception_ctrl_int_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift chain; the line appears at q_o after exactly STAGES rising edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception/interrupt arbiter: CP0 bypass, priority encoding, and a
// FLUSH/DRAIN sequencer that emits flush, redirect PC and CP0 update strobes.
module exception_ctrl
   import exception_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int          SYNC_STAGES  = 2,
   parameter int          DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  hw_int_i,
   input  logic        timer_int_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   input  logic [31:0] mem_pc_i,
   input  logic [4:0]  mem_exc_i,
   input  logic        mem_bd_i,
   output logic [5:0]  int_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        exc_we_o,
   output logic [4:0]  exc_code_o,
   output logic [31:0] exc_epc_o,
   output logic        exc_bd_o,
   output logic        exl_clr_o
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   logic [5:0]       sync_s;
   logic [31:0]      eff_status_d;
   logic [31:0]      eff_cause_d;
   logic [31:0]      eff_epc_d;
   logic             pc_valid_d;
   logic             int_pend_d;
   logic             take_d;
   logic             eret_d;
   logic [4:0]       code_d;
   logic             unused_cp0_bits_s;

   state_e           state_q;
   logic [CNT_W-1:0] drain_cnt_q;
   logic             flush_q;
   logic [31:0]      new_pc_q;
   logic             exc_we_q;
   logic [4:0]       exc_code_q;
   logic [31:0]      exc_epc_q;
   logic             exc_bd_q;
   logic             exl_clr_q;

   for (genvar g = 0; g < 6; g++) begin : g_sync
      exception_ctrl_int_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .d_i (hw_int_i[g]),
         .q_o (sync_s[g])
      );
   end

   assign int_o = {sync_s[5] | timer_int_i, sync_s[4:0]};

   // WB-stage CP0 write bypass; Cause is only software-writable in IP[1:0] and [23:22].
   always_comb begin
      eff_status_d = cp0_status_i;
      eff_cause_d  = cp0_cause_i;
      eff_epc_d    = cp0_epc_i;
      case ({wb_cp0_we_i, wb_cp0_waddr_i})
         {1'b1, CP0_STATUS}: eff_status_d = wb_cp0_data_i;
         {1'b1, CP0_CAUSE}: begin
            eff_cause_d[9:8]   = wb_cp0_data_i[9:8];
            eff_cause_d[23:22] = wb_cp0_data_i[23:22];
         end
         {1'b1, CP0_EPC}:    eff_epc_d = wb_cp0_data_i;
         default:            eff_epc_d = cp0_epc_i;
      endcase
   end

   assign unused_cp0_bits_s = ^{eff_status_d[31:16], eff_status_d[7:2],
                                eff_cause_d[31:16], eff_cause_d[7:0]};

   // Fixed-priority pick among the pending interrupt and MEM-stage requests.
   always_comb begin
      pc_valid_d = (mem_pc_i != 32'd0);
      int_pend_d = eff_status_d[0] & ~eff_status_d[1]
                 & (|(eff_cause_d[15:8] & eff_status_d[15:8])) & pc_valid_d;
      take_d     = 1'b0;
      eret_d     = 1'b0;
      code_d     = EXC_INT;
      if (!pc_valid_d) begin
         take_d = 1'b0;
      end else if (int_pend_d) begin
         take_d = 1'b1;
         code_d = EXC_INT;
      end else if (mem_exc_i[EXC_BIT_SYSCALL]) begin
         take_d = 1'b1;
         code_d = EXC_SYS;
      end else if (mem_exc_i[EXC_BIT_RI]) begin
         take_d = 1'b1;
         code_d = EXC_RI;
      end else if (mem_exc_i[EXC_BIT_OV]) begin
         take_d = 1'b1;
         code_d = EXC_OV;
      end else if (mem_exc_i[EXC_BIT_TRAP]) begin
         take_d = 1'b1;
         code_d = EXC_TRAP;
      end else if (mem_exc_i[EXC_BIT_ERET]) begin
         take_d = 1'b1;
         eret_d = 1'b1;
      end else begin
         take_d = 1'b0;
      end
   end

   // Sequencer: IDLE captures an event, FLUSH pulses strobes, DRAIN swallows requests.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         drain_cnt_q <= '0;
         flush_q     <= 1'b0;
         new_pc_q    <= 32'd0;
         exc_we_q    <= 1'b0;
         exc_code_q  <= 5'd0;
         exc_epc_q   <= 32'd0;
         exc_bd_q    <= 1'b0;
         exl_clr_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (take_d) begin
                  state_q <= ST_FLUSH;
                  flush_q <= 1'b1;
                  if (eret_d) begin
                     exc_we_q  <= 1'b0;
                     exl_clr_q <= 1'b1;
                     new_pc_q  <= eff_epc_d;
                  end else begin
                     exc_we_q   <= 1'b1;
                     exl_clr_q  <= 1'b0;
                     exc_code_q <= code_d;
                     exc_bd_q   <= mem_bd_i;
                     exc_epc_q  <= fault_epc(mem_pc_i, mem_bd_i);
                     new_pc_q   <= EXC_VECTOR;
                  end
               end else begin
                  flush_q   <= 1'b0;
                  exc_we_q  <= 1'b0;
                  exl_clr_q <= 1'b0;
               end
            end
            ST_FLUSH: begin
               state_q     <= ST_DRAIN;
               drain_cnt_q <= CNT_W'(DRAIN_CYCLES - 1);
               flush_q     <= 1'b0;
               exc_we_q    <= 1'b0;
               exl_clr_q   <= 1'b0;
            end
            ST_DRAIN: begin
               flush_q   <= 1'b0;
               exc_we_q  <= 1'b0;
               exl_clr_q <= 1'b0;
               if (drain_cnt_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  drain_cnt_q <= drain_cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               flush_q   <= 1'b0;
               exc_we_q  <= 1'b0;
               exl_clr_q <= 1'b0;
            end
         endcase
      end
   end

   assign flush_o    = flush_q;
   assign new_pc_o   = new_pc_q;
   assign exc_we_o   = exc_we_q;
   assign exc_code_o = exc_code_q;
   assign exc_epc_o  = exc_epc_q;
   assign exc_bd_o   = exc_bd_q;
   assign exl_clr_o  = exl_clr_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: vector table plus scoreboard-checked
// flush events and directed sequences for synchroniser, drain and reset corners.
module tb_exception_ctrl;
   import exception_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  hw_int_i;
   logic        timer_int_i;
   logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic [31:0] mem_pc_i;
   logic [4:0]  mem_exc_i;
   logic        mem_bd_i;
   logic [5:0]  int_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        exc_we_o;
   logic [4:0]  exc_code_o;
   logic [31:0] exc_epc_o;
   logic        exc_bd_o;
   logic        exl_clr_o;

   always #5 clk = ~clk;

   exception_ctrl dut (
      .clk(clk), .rst(rst), .hw_int_i(hw_int_i), .timer_int_i(timer_int_i),
      .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
      .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
      .mem_pc_i(mem_pc_i), .mem_exc_i(mem_exc_i), .mem_bd_i(mem_bd_i),
      .int_o(int_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .exc_we_o(exc_we_o),
      .exc_code_o(exc_code_o), .exc_epc_o(exc_epc_o), .exc_bd_o(exc_bd_o), .exl_clr_o(exl_clr_o)
   );

   typedef struct {
      logic [31:0] st, cause, epc;
      logic        wb_we;
      logic [4:0]  waddr;
      logic [31:0] wdata, pc;
      logic [4:0]  exc;
      logic        bd;
      logic        take, eret;
      logic [4:0]  code;
      logic [31:0] epc_o;
      logic        bd_o;
      logic [31:0] npc;
   } vec_t;

   typedef struct packed {
      logic        eret;
      logic [4:0]  code;
      logic [31:0] epc;
      logic        bd;
      logic [31:0] npc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bubble();
      mem_pc_i    = 32'd0;
      mem_exc_i   = 5'd0;
      mem_bd_i    = 1'b0;
      wb_cp0_we_i = 1'b0;
   endtask

   task automatic drive_req(input logic [31:0] pc, input logic [4:0] exc, input logic bd);
      cp0_status_i = 32'd0;
      cp0_cause_i  = 32'd0;
      wb_cp0_we_i  = 1'b0;
      mem_pc_i     = pc;
      mem_exc_i    = exc;
      mem_bd_i     = bd;
   endtask

   // Scoreboard: every flush pops one expected event; strobes must never appear alone.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (flush_o) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_flush", 32'(flush_o), 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("new_pc", new_pc_o, mon_e.npc);
               chk("exl_clr", 32'(exl_clr_o), 32'(mon_e.eret));
               chk("exc_we", 32'(exc_we_o), 32'(!mon_e.eret));
               if (!mon_e.eret) begin
                  chk("exc_code", 32'(exc_code_o), 32'(mon_e.code));
                  chk("exc_epc", exc_epc_o, mon_e.epc);
                  chk("exc_bd", 32'(exc_bd_o), 32'(mon_e.bd));
               end
            end
         end else begin
            chk("strobe_without_flush", 32'({exc_we_o, exl_clr_o}), 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // st, cause, epc, wb_we, waddr, wdata, pc, exc, bd | take, eret, code, epc_o, bd_o, npc
      vecs.push_back('{32'h0000FF01, 32'h00000400, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000100, 5'b00000, 1'b0, 1'b1, 1'b0, 5'h00, 32'h80000100, 1'b0, 32'h20});
      vecs.push_back('{32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000204, 5'b00001, 1'b1, 1'b1, 1'b0, 5'h08, 32'h80000200, 1'b1, 32'h20});
      vecs.push_back('{32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000300, 5'b00010, 1'b0, 1'b1, 1'b0, 5'h0a, 32'h80000300, 1'b0, 32'h20});
      vecs.push_back('{32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000400, 5'b00100, 1'b1, 1'b1, 1'b0, 5'h0c, 32'h800003FC, 1'b1, 32'h20});
      vecs.push_back('{32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000500, 5'b01000, 1'b0, 1'b1, 1'b0, 5'h0d, 32'h80000500, 1'b0, 32'h20});
      vecs.push_back('{32'h0, 32'h0, 32'h1000, 1'b1, 5'd14, 32'h2000, 32'h80000600, 5'b10000, 1'b0, 1'b1, 1'b1, 5'h00, 32'h0, 1'b0, 32'h2000});
      vecs.push_back('{32'h0, 32'h0, 32'h1234, 1'b0, 5'd14, 32'h9999, 32'h80000610, 5'b10000, 1'b0, 1'b1, 1'b1, 5'h00, 32'h0, 1'b0, 32'h1234});
      vecs.push_back('{32'h0, 32'h0, 32'h5678, 1'b1, 5'd12, 32'h0, 32'h80000620, 5'b10000, 1'b0, 1'b1, 1'b1, 5'h00, 32'h0, 1'b0, 32'h5678});
      vecs.push_back('{32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000700, 5'b11111, 1'b0, 1'b1, 1'b0, 5'h08, 32'h80000700, 1'b0, 32'h20});
      vecs.push_back('{32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000710, 5'b00110, 1'b0, 1'b1, 1'b0, 5'h0a, 32'h80000710, 1'b0, 32'h20});
      vecs.push_back('{32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000720, 5'b11100, 1'b0, 1'b1, 1'b0, 5'h0c, 32'h80000720, 1'b0, 32'h20});
      vecs.push_back('{32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000730, 5'b11000, 1'b0, 1'b1, 1'b0, 5'h0d, 32'h80000730, 1'b0, 32'h20});
      vecs.push_back('{32'h0000FF01, 32'h00000400, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000800, 5'b00001, 1'b1, 1'b1, 1'b0, 5'h00, 32'h800007FC, 1'b1, 32'h20});
      vecs.push_back('{32'h0000FF03, 32'h00000400, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000810, 5'b00001, 1'b0, 1'b1, 1'b0, 5'h08, 32'h80000810, 1'b0, 32'h20});
      vecs.push_back('{32'h0, 32'h00000400, 32'h0, 1'b1, 5'd12, 32'h0000FF01, 32'h80000820, 5'b00000, 1'b0, 1'b1, 1'b0, 5'h00, 32'h80000820, 1'b0, 32'h20});
      vecs.push_back('{32'h0000FF01, 32'h0, 32'h0, 1'b1, 5'd13, 32'h00000100, 32'h80000830, 5'b00000, 1'b0, 1'b1, 1'b0, 5'h00, 32'h80000830, 1'b0, 32'h20});
      vecs.push_back('{32'h0000FF01, 32'h0, 32'h0, 1'b1, 5'd13, 32'h00000400, 32'h80000840, 5'b00010, 1'b0, 1'b1, 1'b0, 5'h0a, 32'h80000840, 1'b0, 32'h20});
      vecs.push_back('{32'h0000FF01, 32'h00000400, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 5'b00001, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0});
      vecs.push_back('{32'h0000FF00, 32'h00000400, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000850, 5'b00000, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0});
      vecs.push_back('{32'h0000FE01, 32'h00000100, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000860, 5'b00000, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0});
      vecs.push_back('{32'h0000FF01, 32'h00000100, 32'h0, 1'b1, 5'd13, 32'h0, 32'h80000870, 5'b00000, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0});

      rst = 1'b0;
      hw_int_i = 6'd0;
      timer_int_i = 1'b0;
      cp0_status_i = 32'd0;
      cp0_cause_i = 32'd0;
      cp0_epc_i = 32'd0;
      wb_cp0_waddr_i = 5'd0;
      wb_cp0_data_i = 32'd0;
      bubble();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_flush", 32'(flush_o), 32'd0);
      chk("reset_outputs", 32'({exc_we_o, exl_clr_o, exc_bd_o, exc_code_o, int_o}), 32'd0);
      chk("reset_new_pc", new_pc_o, 32'd0);
      chk("reset_epc", exc_epc_o, 32'd0);

      // Synchroniser latency and timer pass-through.
      @(negedge clk);
      rst = 1'b1;
      hw_int_i = 6'b000001;
      @(negedge clk);
      chk("sync_after_1_edge", 32'(int_o), 32'd0);
      @(negedge clk);
      chk("sync_after_2_edges", 32'(int_o), 32'h01);
      timer_int_i = 1'b1;
      #1;
      chk("timer_comb", 32'(int_o), 32'h21);
      timer_int_i = 1'b0;
      hw_int_i = 6'd0;

      foreach (vecs[i]) begin
         @(negedge clk);
         cp0_status_i   = vecs[i].st;
         cp0_cause_i    = vecs[i].cause;
         cp0_epc_i      = vecs[i].epc;
         wb_cp0_we_i    = vecs[i].wb_we;
         wb_cp0_waddr_i = vecs[i].waddr;
         wb_cp0_data_i  = vecs[i].wdata;
         mem_pc_i       = vecs[i].pc;
         mem_exc_i      = vecs[i].exc;
         mem_bd_i       = vecs[i].bd;
         if (vecs[i].take)
            sb_q.push_back('{vecs[i].eret, vecs[i].code, vecs[i].epc_o, vecs[i].bd_o, vecs[i].npc});
         @(negedge clk);
         bubble();
         repeat (2) @(negedge clk);
         #1;
         chk($sformatf("vec%0d_serviced", i), 32'(sb_q.size()), 32'd0);
      end

      // Back-to-back overflow: only the first is taken, the drain window is exact.
      @(negedge clk);
      drive_req(32'h80001000, 5'b00100, 1'b0);
      sb_q.push_back('{1'b0, EXC_OV, 32'h80001000, 1'b0, 32'h20});
      @(negedge clk);
      mem_pc_i = 32'h80001004;
      @(negedge clk);
      mem_pc_i = 32'h80001008;
      @(negedge clk);
      mem_pc_i = 32'h8000100C;
      @(negedge clk);
      drive_req(32'h80001010, 5'b00001, 1'b0);
      sb_q.push_back('{1'b0, EXC_SYS, 32'h80001010, 1'b0, 32'h20});
      @(negedge clk);
      bubble();
      repeat (2) @(negedge clk);
      #1;
      chk("drain_sequence_serviced", 32'(sb_q.size()), 32'd0);

      // Reset during FLUSH drops outputs at once; next request is serviced normally.
      @(negedge clk);
      drive_req(32'h80002000, 5'b00001, 1'b0);
      @(posedge clk);
      #1;
      chk("flush_before_reset", 32'(flush_o), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      chk("flush_async_reset", 32'(flush_o), 32'd0);
      chk("we_async_reset", 32'(exc_we_o), 32'd0);
      chk("new_pc_async_reset", new_pc_o, 32'd0);
      @(negedge clk);
      bubble();
      rst = 1'b1;
      @(negedge clk);
      drive_req(32'h80002100, 5'b00010, 1'b0);
      sb_q.push_back('{1'b0, EXC_RI, 32'h80002100, 1'b0, 32'h20});
      @(negedge clk);
      bubble();
      repeat (2) @(negedge clk);
      #1;
      chk("post_reset_serviced", 32'(sb_q.size()), 32'd0);
      chk("hold_new_pc", new_pc_o, 32'h20);
      chk("hold_code", 32'(exc_code_o), 32'(EXC_RI));
      chk("hold_epc", exc_epc_o, 32'h80002100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
